// File: rtl/approx_sweep_checker.sv
// Exhaustive sweep sequencer for an approximate adder: drives every input vector,
// compares the response against the exact sum and accumulates error statistics.
module approx_sweep_checker #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 3,
    parameter int ET    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [IN_W-1:0]       dut_in,
    input  logic [OUT_W-1:0]      dut_out,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      max_err,
    output logic [IN_W:0]         err_count,
    output logic [IN_W+OUT_W-1:0] err_sum,
    output logic [IN_W-1:0]       first_fail_vec,
    output logic                  fail_seen,
    output logic                  pass
);
    localparam int HALF = IN_W / 2;
    localparam logic [IN_W-1:0]  LAST_VEC = {IN_W{1'b1}};
    localparam logic [OUT_W-1:0] ET_V     = OUT_W'(ET);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_r;
    logic [IN_W-1:0]      s1_vec_r;
    logic [OUT_W-1:0]     s1_out_r;
    logic [OUT_W-1:0]     s1_exact_r;
    logic                 valid1_r;
    logic [OUT_W-1:0]     exact_s;
    logic [OUT_W-1:0]     err_s;
    logic                 viol_s;
    logic [IN_W:0]        err_count_next_s;

    function automatic logic [OUT_W-1:0] abs_diff(input logic [OUT_W-1:0] x,
                                                  input logic [OUT_W-1:0] y);
        if (x >= y) begin
            return x - y;
        end else begin
            return y - x;
        end
    endfunction

    // Exact reference sum of the vector currently presented to the circuit
    always_comb begin
        exact_s = {1'b0, dut_in[HALF-1:0]} + {1'b0, dut_in[IN_W-1:HALF]};
    end

    // Stage-2 error evaluation of the captured vector
    always_comb begin
        err_s = abs_diff(s1_exact_r, s1_out_r);
        if (valid1_r && (err_s > ET_V)) begin
            viol_s = 1'b1;
        end else begin
            viol_s = 1'b0;
        end
        err_count_next_s = err_count + {{IN_W{1'b0}}, viol_s};
    end

    // Sequencer FSM, capture stage and result accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            dut_in         <= {IN_W{1'b0}};
            busy           <= 1'b0;
            done           <= 1'b0;
            max_err        <= {OUT_W{1'b0}};
            err_count      <= {(IN_W+1){1'b0}};
            err_sum        <= {(IN_W+OUT_W){1'b0}};
            first_fail_vec <= {IN_W{1'b0}};
            fail_seen      <= 1'b0;
            pass           <= 1'b0;
            valid1_r       <= 1'b0;
            s1_vec_r       <= {IN_W{1'b0}};
            s1_out_r       <= {OUT_W{1'b0}};
            s1_exact_r     <= {OUT_W{1'b0}};
        end else begin
            done     <= 1'b0;
            valid1_r <= 1'b0;
            // A vector captured last cycle always lands, even on an abort edge
            if (valid1_r) begin
                max_err   <= (err_s > max_err) ? err_s : max_err;
                err_sum   <= err_sum + {{IN_W{1'b0}}, err_s};
                err_count <= err_count_next_s;
                if (viol_s && !fail_seen) begin
                    first_fail_vec <= s1_vec_r;
                    fail_seen      <= 1'b1;
                end
            end
            case (state_r)
                IDLE: begin
                    dut_in <= {IN_W{1'b0}};
                    if (start && !abort) begin
                        state_r        <= SWEEP;
                        busy           <= 1'b1;
                        max_err        <= {OUT_W{1'b0}};
                        err_count      <= {(IN_W+1){1'b0}};
                        err_sum        <= {(IN_W+OUT_W){1'b0}};
                        first_fail_vec <= {IN_W{1'b0}};
                        fail_seen      <= 1'b0;
                        pass           <= 1'b0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        dut_in  <= {IN_W{1'b0}};
                    end else begin
                        s1_vec_r   <= dut_in;
                        s1_out_r   <= dut_out;
                        s1_exact_r <= exact_s;
                        valid1_r   <= 1'b1;
                        if (dut_in == LAST_VEC) begin
                            state_r <= DRAIN;
                            dut_in  <= {IN_W{1'b0}};
                        end else begin
                            dut_in <= dut_in + {{(IN_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                DRAIN: begin
                    state_r <= abort ? IDLE : DONE;
                    busy    <= 1'b0;
                    if (!abort) begin
                        done <= 1'b1;
                        pass <= (err_count_next_s == {(IN_W+1){1'b0}});
                    end else begin
                        done <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    dut_in  <= {IN_W{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_approx_sweep_checker.sv
// Directed/randomised bench for approx_sweep_checker; two instances (ET=4 and ET=0)
// share stimulus and are compared against an exhaustive arithmetic reference.
module tb_approx_sweep_checker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    int         mode = 0;
    logic [47:0] lut_bits = 48'd0;
    int         checks = 0;
    int         errors = 0;

    logic [3:0] dut_in_a, dut_in_b, ffv_a, ffv_b;
    logic [2:0] dut_out_a, dut_out_b, max_err_a, max_err_b;
    logic [4:0] cnt_a, cnt_b;
    logic [6:0] sum_a, sum_b;
    logic       busy_a, busy_b, done_a, done_b, seen_a, seen_b, pass_a, pass_b;

    always #5 clk = ~clk;

    // Behavioural approximate circuit: 0 exact, 1 zero, 2 lsb forced, 3 random table
    function automatic logic [2:0] approx(input logic [3:0] v, input int m, input logic [47:0] l);
        logic [2:0] s;
        s = {1'b0, v[1:0]} + {1'b0, v[3:2]};
        case (m)
            0: return s;
            1: return 3'd0;
            2: return s | 3'd1;
            default: return l[v*3 +: 3];
        endcase
    endfunction

    assign dut_out_a = approx(dut_in_a, mode, lut_bits);
    assign dut_out_b = approx(dut_in_b, mode, lut_bits);

    approx_sweep_checker #(.IN_W(4), .OUT_W(3), .ET(4)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
        .max_err(max_err_a), .err_count(cnt_a), .err_sum(sum_a),
        .first_fail_vec(ffv_a), .fail_seen(seen_a), .pass(pass_a));

    approx_sweep_checker #(.IN_W(4), .OUT_W(3), .ET(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
        .max_err(max_err_b), .err_count(cnt_b), .err_sum(sum_b),
        .first_fail_vec(ffv_b), .fail_seen(seen_b), .pass(pass_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk all vectors with plain integer arithmetic
    task automatic ref_model(input int et, output int e_max, output int e_cnt, output int e_sum,
                             output int e_first, output int e_seen, output int e_pass);
        e_max = 0; e_cnt = 0; e_sum = 0; e_first = 0;
        for (int v = 0; v < 16; v++) begin
            int a, b, ex, o, e;
            a  = v % 4;
            b  = v / 4;
            ex = a + b;
            o  = int'(approx(4'(v), mode, lut_bits));
            e  = (ex > o) ? ex - o : o - ex;
            if (e > e_max) e_max = e;
            e_sum += e;
            if (e > et) begin
                if (e_cnt == 0) e_first = v;
                e_cnt++;
            end
        end
        e_seen = (e_cnt > 0) ? 1 : 0;
        e_pass = (e_cnt == 0) ? 1 : 0;
    endtask

    task automatic check_results(input string tag);
        int mx, cn, sm, ff, sn, ps;
        ref_model(4, mx, cn, sm, ff, sn, ps);
        check({tag, " max_err_a"}, 32'(max_err_a), mx);
        check({tag, " err_count_a"}, 32'(cnt_a), cn);
        check({tag, " err_sum_a"}, 32'(sum_a), sm);
        check({tag, " first_fail_a"}, 32'(ffv_a), ff);
        check({tag, " fail_seen_a"}, 32'(seen_a), sn);
        check({tag, " pass_a"}, 32'(pass_a), ps);
        ref_model(0, mx, cn, sm, ff, sn, ps);
        check({tag, " err_count_b"}, 32'(cnt_b), cn);
        check({tag, " err_sum_b"}, 32'(sum_b), sm);
        check({tag, " first_fail_b"}, 32'(ffv_b), ff);
        check({tag, " pass_b"}, 32'(pass_b), ps);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " busy"}, 32'(busy_a), 0);
        check({tag, " done"}, 32'(done_a), 0);
        check({tag, " dut_in"}, 32'(dut_in_a), 0);
        check({tag, " max_err"}, 32'(max_err_a), 0);
        check({tag, " err_count"}, 32'(cnt_a), 0);
        check({tag, " err_sum"}, 32'(sum_a), 0);
        check({tag, " first_fail"}, 32'(ffv_a), 0);
        check({tag, " fail_seen"}, 32'(seen_a), 0);
        check({tag, " pass"}, 32'(pass_a), 0);
    endtask

    // Full sweep: start sampled at E0, vector k in cycle k+1, DRAIN 17, done 18
    task automatic sweep(input string tag, input bit hold);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            check({tag, " dut_in"}, 32'(dut_in_a), cyc - 1);
            check({tag, " busy"}, 32'(busy_a), 1);
            @(posedge clk); #1;
        end
        check({tag, " drain busy"}, 32'(busy_a), 1);
        check({tag, " drain done"}, 32'(done_a), 0);
        @(posedge clk); #1;
        check({tag, " done_a"}, 32'(done_a), 1);
        check({tag, " done_b"}, 32'(done_b), 1);
        check({tag, " done busy"}, 32'(busy_a), 0);
        check_results(tag);
        @(posedge clk); #1;
        check({tag, " done pulse end"}, 32'(done_a), 0);
        check({tag, " idle busy"}, 32'(busy_a), 0);
        check_results({tag, " hold"});
    endtask

    initial begin
        logic [63:0] r64;
        bit saw_done;
        #1;
        check_reset("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset("post reset idle");

        mode = 0; sweep("exact", 1'b0);
        mode = 1; sweep("zero", 1'b0);
        mode = 2; sweep("lsb1", 1'b0);
        for (int i = 0; i < 3; i++) begin
            r64 = {$urandom(), $urandom()};
            lut_bits = r64[47:0];
            mode = 3;
            sweep("random", 1'b0);
        end

        // Abort in cycle 9
        mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort busy", 32'(busy_a), 0);
        check("abort dut_in", 32'(dut_in_a), 0);
        check("abort pass", 32'(pass_a), 0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done_a || done_b) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check("abort no done", 32'(saw_done), 0);
        check("abort pass hold", 32'(pass_a), 0);
        sweep("after abort", 1'b0);

        // Start held high: no restart until IDLE, then restarts
        mode = 0;
        sweep("held start", 1'b1);
        @(posedge clk); #1;
        check("held restart busy", 32'(busy_a), 1);
        check("held restart dut_in", 32'(dut_in_a), 0);
        check("held restart pass cleared", 32'(pass_a), 0);
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("held abort busy", 32'(busy_a), 0);

        // Async reset during DRAIN
        mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check("pre-reset drain busy", 32'(busy_a), 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset("reset in drain");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("no resume busy", 32'(busy_a), 0);
        check("no resume done", 32'(done_a), 0);
        mode = 2;
        sweep("after reset", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
